vram_slot_arbiter: RTL and testbench

Time-division arbiter for the single-port 32Kx8 VRAM. It shares the memory between three requesters: the display fetch pipeline, CPU reads and writes through a write FIFO, and a block-fill engine. Each character time is split into eight access slots, advanced on the dot-clock enable. Display slots are fixed and guaranteed; the remaining slots are granted to CPU and fill traffic by fixed priority.

---
 rtl/vram_slot_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vram_slot_arbiter
// Brief  : Eight-slot time-division arbiter sharing one VRAM port between the
//          display fetch, CPU reads/writes (via a write FIFO) and a fill engine.
// Rev    : 1.0 - initial release
// ============================================================================
module vram_slot_arbiter #(
   parameter int ADDR_W      = 15,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              slot_en_i,
   output logic [2:0]        slot_o,
   input  logic [ADDR_W-1:0] disp_addr_i,
   output logic              disp_fetch_o,
   input  logic              cpu_wr_valid_i,
   output logic              cpu_wr_ready_o,
   input  logic [ADDR_W-1:0] cpu_wr_addr_i,
   input  logic [7:0]        cpu_wr_data_i,
   input  logic              cpu_rd_req_i,
   input  logic [ADDR_W-1:0] cpu_rd_addr_i,
   output logic              cpu_rd_busy_o,
   output logic              cpu_rd_valid_o,
   output logic [7:0]        cpu_rd_data_o,
   input  logic              fill_start_i,
   input  logic [ADDR_W-1:0] fill_addr_i,
   input  logic [15:0]       fill_len_i,
   input  logic [7:0]        fill_value_i,
   output logic              fill_busy_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [7:0]        ram_wdata_o,
   input  logic [7:0]        ram_rdata_i
);

   localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(WFIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WFIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [0:0] {
      FILL_IDLE = 1'b0,
      FILL_RUN  = 1'b1
   } fill_state_t;

   // Slot counter
   logic [2:0] slot_q, slot_d;

   // Write FIFO
   logic [ADDR_W-1:0] wf_addr_q [WFIFO_DEPTH];
   logic [7:0]        wf_data_q [WFIFO_DEPTH];
   logic [PTR_W-1:0]  wf_wptr_q, wf_rptr_q;
   logic [CNT_W-1:0]  wf_cnt_q, wf_cnt_d;
   logic              fifo_push, fifo_pop, fifo_ne;

   // CPU read
   logic              rd_busy_q, rd_inflight_q, rd_valid_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [7:0]        rd_data_q;
   logic              rd_pend;

   // Fill engine
   fill_state_t       fill_state_q;
   logic [ADDR_W-1:0] fill_addr_q;
   logic [15:0]       fill_len_q;
   logic [7:0]        fill_val_q;
   logic              fill_rdy;

   // RAM port
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [7:0]        ram_wdata_q;

   logic disp_slot, cpu_slot;
   logic gnt_wr, gnt_rd, gnt_fill;

   assign disp_slot = (slot_q < 3'd3);
   assign cpu_slot  = (slot_q == 3'd3) || (slot_q == 3'd7);
   assign fifo_ne   = (wf_cnt_q != '0);
   assign rd_pend   = rd_busy_q && !rd_inflight_q;
   assign fill_rdy  = (fill_state_q == FILL_RUN) && (fill_len_q != 16'd0);

   // A read is only reachable once the FIFO is empty, so it observes all earlier CPU writes.
   always_comb begin
      gnt_wr   = 1'b0;
      gnt_rd   = 1'b0;
      gnt_fill = 1'b0;
      if (!disp_slot) begin
         if (cpu_slot) begin
            if (fifo_ne)       gnt_wr   = 1'b1;
            else if (rd_pend)  gnt_rd   = 1'b1;
            else if (fill_rdy) gnt_fill = 1'b1;
         end else begin
            if (fill_rdy)      gnt_fill = 1'b1;
            else if (fifo_ne)  gnt_wr   = 1'b1;
            else if (rd_pend)  gnt_rd   = 1'b1;
         end
      end
   end

   assign slot_d = slot_en_i ? (slot_q + 3'd1) : slot_q;

   always_ff @(posedge clk) begin
      if (reset) slot_q <= 3'd0;
      else       slot_q <= slot_d;
   end

   assign fifo_push = cpu_wr_valid_i && cpu_wr_ready_o;
   assign fifo_pop  = slot_en_i && gnt_wr;

   always_comb begin
      wf_cnt_d = wf_cnt_q;
      if (fifo_push && !fifo_pop)      wf_cnt_d = wf_cnt_q + CNT_ONE;
      else if (!fifo_push && fifo_pop) wf_cnt_d = wf_cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wf_wptr_q <= '0;
         wf_rptr_q <= '0;
         wf_cnt_q  <= '0;
      end else begin
         wf_cnt_q <= wf_cnt_d;
         if (fifo_push) wf_wptr_q <= wf_wptr_q + PTR_ONE;
         if (fifo_pop)  wf_rptr_q <= wf_rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         wf_addr_q[wf_wptr_q] <= cpu_wr_addr_i;
         wf_data_q[wf_wptr_q] <= cpu_wr_data_i;
      end
   end

   // Read data is sampled on the slot following the one that drove its address.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_busy_q     <= 1'b0;
         rd_inflight_q <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_addr_q     <= '0;
         rd_data_q     <= 8'd0;
      end else begin
         rd_valid_q <= 1'b0;
         if (!rd_busy_q && cpu_rd_req_i) begin
            rd_busy_q <= 1'b1;
            rd_addr_q <= cpu_rd_addr_i;
         end
         if (slot_en_i && gnt_rd) rd_inflight_q <= 1'b1;
         if (slot_en_i && rd_inflight_q) begin
            rd_data_q     <= ram_rdata_i;
            rd_valid_q    <= 1'b1;
            rd_busy_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_state_q <= FILL_IDLE;
         fill_addr_q  <= '0;
         fill_len_q   <= 16'd0;
         fill_val_q   <= 8'd0;
      end else begin
         case (fill_state_q)
            FILL_IDLE: begin
               if (fill_start_i && (fill_len_i != 16'd0)) begin
                  fill_addr_q  <= fill_addr_i;
                  fill_len_q   <= fill_len_i;
                  fill_val_q   <= fill_value_i;
                  fill_state_q <= FILL_RUN;
               end
            end
            FILL_RUN: begin
               if (fill_len_q == 16'd0) begin
                  fill_state_q <= FILL_IDLE;
               end else if (slot_en_i && gnt_fill) begin
                  fill_addr_q <= fill_addr_q + ADDR_ONE;
                  fill_len_q  <= fill_len_q - 16'd1;
               end
            end
            default: fill_state_q <= FILL_IDLE;
         endcase
      end
   end

   // Unused slots leave the address parked and only drop the write enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= 8'd0;
      end else if (slot_en_i) begin
         if (disp_slot) begin
            ram_addr_q <= disp_addr_i;
            ram_we_q   <= 1'b0;
         end else if (gnt_wr) begin
            ram_addr_q  <= wf_addr_q[wf_rptr_q];
            ram_wdata_q <= wf_data_q[wf_rptr_q];
            ram_we_q    <= 1'b1;
         end else if (gnt_rd) begin
            ram_addr_q <= rd_addr_q;
            ram_we_q   <= 1'b0;
         end else if (gnt_fill) begin
            ram_addr_q  <= fill_addr_q;
            ram_wdata_q <= fill_val_q;
            ram_we_q    <= 1'b1;
         end else begin
            ram_we_q <= 1'b0;
         end
      end
   end

   assign slot_o         = slot_q;
   assign disp_fetch_o   = (slot_q != 3'd0) && (slot_q < 3'd4);
   assign cpu_wr_ready_o = (wf_cnt_q != CNT_FULL);
   assign cpu_rd_busy_o  = rd_busy_q;
   assign cpu_rd_valid_o = rd_valid_q;
   assign cpu_rd_data_o  = rd_data_q;
   assign fill_busy_o    = (fill_state_q == FILL_RUN);
   assign ram_addr_o     = ram_addr_q;
   assign ram_we_o       = ram_we_q;
   assign ram_wdata_o    = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vram_slot_arbiter
// Brief  : Directed self-checking bench for vram_slot_arbiter with a VRAM model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vram_slot_arbiter;

   logic        clk;
   logic        reset;
   logic        slot_en_i;
   logic [2:0]  slot_o;
   logic [14:0] disp_addr_i;
   logic        disp_fetch_o;
   logic        cpu_wr_valid_i;
   logic        cpu_wr_ready_o;
   logic [14:0] cpu_wr_addr_i;
   logic [7:0]  cpu_wr_data_i;
   logic        cpu_rd_req_i;
   logic [14:0] cpu_rd_addr_i;
   logic        cpu_rd_busy_o;
   logic        cpu_rd_valid_o;
   logic [7:0]  cpu_rd_data_o;
   logic        fill_start_i;
   logic [14:0] fill_addr_i;
   logic [15:0] fill_len_i;
   logic [7:0]  fill_value_i;
   logic        fill_busy_o;
   logic [14:0] ram_addr_o;
   logic        ram_we_o;
   logic [7:0]  ram_wdata_o;
   logic [7:0]  ram_rdata_i;

   vram_slot_arbiter #(.ADDR_W(15), .WFIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .slot_en_i(slot_en_i), .slot_o(slot_o),
      .disp_addr_i(disp_addr_i), .disp_fetch_o(disp_fetch_o),
      .cpu_wr_valid_i(cpu_wr_valid_i), .cpu_wr_ready_o(cpu_wr_ready_o),
      .cpu_wr_addr_i(cpu_wr_addr_i), .cpu_wr_data_i(cpu_wr_data_i),
      .cpu_rd_req_i(cpu_rd_req_i), .cpu_rd_addr_i(cpu_rd_addr_i),
      .cpu_rd_busy_o(cpu_rd_busy_o), .cpu_rd_valid_o(cpu_rd_valid_o),
      .cpu_rd_data_o(cpu_rd_data_o), .fill_start_i(fill_start_i),
      .fill_addr_i(fill_addr_i), .fill_len_i(fill_len_i),
      .fill_value_i(fill_value_i), .fill_busy_o(fill_busy_o),
      .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:32767];
   always @(posedge clk) if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
   assign ram_rdata_i = mem[ram_addr_o];

   typedef struct {
      logic [2:0]  slot;
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  wlog[$];
   wr_t  mon_e;
   logic se_q;

   // Each slot_en edge that leaves ram_we high is one distinct write, issued by slot_o-1.
   always @(posedge clk) se_q <= slot_en_i;
   always @(negedge clk) begin
      if (se_q && ram_we_o && !reset) begin
         mon_e.slot = slot_o - 3'd1;
         mon_e.addr = ram_addr_o;
         mon_e.data = ram_wdata_o;
         wlog.push_back(mon_e);
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic se);
      slot_en_i = se;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [2:0]  prev_slot;
      logic [14:0] prev_addr;
      logic [14:0] ea;
      logic        se;
      int          g, pulses, cw, fw, cpu_err, fill_err, n_cpu, n_fill, bad;
      logic [7:0]  rd_got;
      logic        push_now, filling;
      wr_t         exp_q[$];
      wr_t         e;

      reset = 1'b1; slot_en_i = 1'b0; disp_addr_i = '0;
      cpu_wr_valid_i = 1'b0; cpu_wr_addr_i = '0; cpu_wr_data_i = '0;
      cpu_rd_req_i = 1'b0; cpu_rd_addr_i = '0;
      fill_start_i = 1'b0; fill_addr_i = '0; fill_len_i = '0; fill_value_i = '0;
      @(negedge clk); #1;
      step(1'b0); step(1'b1); step(1'b0);

      check_eq("rst_slot", {29'd0, slot_o}, 0);
      check_eq("rst_ram_addr", {17'd0, ram_addr_o}, 0);
      check_eq("rst_ram_we", {31'd0, ram_we_o}, 0);
      check_eq("rst_ram_wdata", {24'd0, ram_wdata_o}, 0);
      check_eq("rst_wr_ready", {31'd0, cpu_wr_ready_o}, 1);
      check_eq("rst_rd_busy", {31'd0, cpu_rd_busy_o}, 0);
      check_eq("rst_rd_valid", {31'd0, cpu_rd_valid_o}, 0);
      check_eq("rst_rd_data", {24'd0, cpu_rd_data_o}, 0);
      check_eq("rst_fill_busy", {31'd0, fill_busy_o}, 0);
      check_eq("rst_disp_fetch", {31'd0, disp_fetch_o}, 0);
      reset = 1'b0;

      // Idle: 16 slot_en pulses interleaved with idle clocks
      for (int i = 0; i < 32; i++) begin
         se          = (i % 2 == 0);
         disp_addr_i = 15'h1230 | {12'd0, slot_o};
         prev_slot   = slot_o;
         prev_addr   = ram_addr_o;
         step(se);
         if (se) begin
            check_eq("idle_slot_adv", {29'd0, slot_o}, {29'd0, prev_slot + 3'd1});
            if (prev_slot < 3'd3)
               check_eq("idle_disp_addr", {17'd0, ram_addr_o}, {17'd0, 15'h1230 | {12'd0, prev_slot}});
            else
               check_eq("idle_addr_hold", {17'd0, ram_addr_o}, {17'd0, prev_addr});
         end else begin
            check_eq("idle_slot_hold", {29'd0, slot_o}, {29'd0, prev_slot});
            check_eq("idle_addr_noen", {17'd0, ram_addr_o}, {17'd0, prev_addr});
         end
         check_eq("idle_we", {31'd0, ram_we_o}, 0);
         check_eq("idle_disp_fetch", {31'd0, disp_fetch_o},
                  {31'd0, (slot_o >= 3'd1) && (slot_o <= 3'd3)});
      end
      check_eq("idle_wrap", {29'd0, slot_o}, 0);

      // Five back-to-back CPU writes; slots frozen so the FIFO fills
      wlog.delete();
      cpu_wr_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_wr_addr_i = 15'h0100 + 15'(i);
         cpu_wr_data_i = 8'hA0 + 8'(i);
         check_eq("wr_ready_fill", {31'd0, cpu_wr_ready_o}, 1);
         step(1'b0);
      end
      cpu_wr_addr_i = 15'h0104;
      cpu_wr_data_i = 8'hA4;
      check_eq("wr_full_stall", {31'd0, cpu_wr_ready_o}, 0);
      g = 0;
      while (!cpu_wr_ready_o && g < 20) begin step(1'b1); g++; end
      check_eq("wr5_unstall", {31'd0, cpu_wr_ready_o}, 1);
      step(1'b1);
      cpu_wr_valid_i = 1'b0;
      repeat (16) step(1'b1);
      check_eq("wr5_count", wlog.size(), 5);
      for (int i = 0; i < wlog.size() && i < 5; i++) begin
         check_eq("wr5_addr", {17'd0, wlog[i].addr}, 32'h0100 + i);
         check_eq("wr5_data", {24'd0, wlog[i].data}, 32'hA0 + i);
         check_eq("wr5_slot_ok", {31'd0, wlog[i].slot >= 3'd3}, 1);
      end

      // Write then immediate read of the same address
      wlog.delete();
      cpu_wr_valid_i = 1'b1; cpu_wr_addr_i = 15'h0200; cpu_wr_data_i = 8'h55;
      step(1'b1);
      cpu_wr_valid_i = 1'b0;
      cpu_rd_req_i = 1'b1; cpu_rd_addr_i = 15'h0200;
      step(1'b1);
      cpu_rd_req_i = 1'b0;
      check_eq("rd_busy_set", {31'd0, cpu_rd_busy_o}, 1);
      pulses = 0; rd_got = 8'h00;
      for (int i = 0; i < 24; i++) begin
         step(1'b1);
         if (cpu_rd_valid_o) begin
            pulses++;
            rd_got = cpu_rd_data_o;
            check_eq("rd_busy_clr", {31'd0, cpu_rd_busy_o}, 0);
         end
      end
      check_eq("rd_pulses", pulses, 1);
      check_eq("rd_data", {24'd0, rd_got}, 32'h55);
      check_eq("rd_data_held", {24'd0, cpu_rd_data_o}, 32'h55);
      check_eq("rd_wr_issued", wlog.size(), 1);

      // Fill across the top of the address space
      wlog.delete();
      fill_start_i = 1'b1; fill_addr_i = 15'h7FFE; fill_len_i = 16'd4; fill_value_i = 8'hEE;
      step(1'b1);
      fill_start_i = 1'b0;
      check_eq("fill_busy_set", {31'd0, fill_busy_o}, 1);
      g = 0;
      while (fill_busy_o && g < 40) begin step(1'b1); g++; end
      check_eq("fill_done", {31'd0, fill_busy_o}, 0);
      check_eq("fill_count", wlog.size(), 4);
      for (int i = 0; i < wlog.size() && i < 4; i++) begin
         ea = 15'h7FFE + 15'(i);
         check_eq("fill_addr", {17'd0, wlog[i].addr}, {17'd0, ea});
         check_eq("fill_data", {24'd0, wlog[i].data}, 32'hEE);
      end
      fill_start_i = 1'b1; fill_len_i = 16'd0;
      step(1'b1);
      fill_start_i = 1'b0;
      check_eq("fill_len0_idle", {31'd0, fill_busy_o}, 0);
      repeat (8) step(1'b1);
      check_eq("fill_len0_nowr", wlog.size(), 4);

      // Long fill concurrent with continuous CPU writes
      g = 0;
      while (slot_o != 3'd0 && g < 16) begin step(1'b1); g++; end
      wlog.delete();
      fill_start_i = 1'b1; fill_addr_i = 15'h1000; fill_len_i = 16'd100; fill_value_i = 8'h77;
      cw = 0; fw = 0; cpu_err = 0; fill_err = 0;
      cpu_wr_valid_i = 1'b1;
      cpu_wr_addr_i = 15'h3000; cpu_wr_data_i = 8'h00;
      for (int i = 0; i < 400 && fw < 100; i++) begin
         push_now  = cpu_wr_valid_i && cpu_wr_ready_o;
         if (push_now) begin
            e.slot = 3'd0; e.addr = cpu_wr_addr_i; e.data = cpu_wr_data_i;
            exp_q.push_back(e);
         end
         prev_slot = slot_o;
         filling   = (i > 0);
         step(1'b1);
         fill_start_i = 1'b0;
         if (push_now) begin
            cw++;
            cpu_wr_addr_i = 15'h3000 + 15'(cw);
            cpu_wr_data_i = 8'(cw);
         end
         if (filling && (prev_slot == 3'd3 || prev_slot == 3'd7))
            if (!(ram_we_o && ram_addr_o >= 15'h3000)) cpu_err++;
         if (filling && prev_slot >= 3'd4 && prev_slot <= 3'd6)
            if (!(ram_we_o && ram_addr_o >= 15'h1000 && ram_addr_o < 15'h1064)) fill_err++;
         if (ram_we_o && ram_addr_o >= 15'h1000 && ram_addr_o < 15'h1064) fw++;
      end
      cpu_wr_valid_i = 1'b0;
      repeat (40) step(1'b1);
      check_eq("mix_fill_complete", fw, 100);
      check_eq("mix_cpu_slot_errs", cpu_err, 0);
      check_eq("mix_fill_slot_errs", fill_err, 0);
      n_cpu = 0; n_fill = 0; bad = 0;
      foreach (wlog[k]) begin
         if (wlog[k].addr >= 15'h3000) begin
            if (n_cpu >= exp_q.size()) bad++;
            else if (wlog[k].addr != exp_q[n_cpu].addr || wlog[k].data != exp_q[n_cpu].data) bad++;
            n_cpu++;
         end else begin
            ea = 15'h1000 + 15'(n_fill);
            if (wlog[k].addr != ea || wlog[k].data != 8'h77) bad++;
            n_fill++;
         end
      end
      check_eq("mix_cpu_count", n_cpu, exp_q.size());
      check_eq("mix_fill_count", n_fill, 100);
      check_eq("mix_order_errs", bad, 0);

      // Reset during a fill with FIFO entries and a pending read
      fill_start_i = 1'b1; fill_addr_i = 15'h2000; fill_len_i = 16'd50; fill_value_i = 8'h99;
      step(1'b0);
      fill_start_i = 1'b0;
      cpu_wr_valid_i = 1'b1; cpu_wr_addr_i = 15'h4000; cpu_wr_data_i = 8'h01;
      step(1'b0);
      cpu_wr_addr_i = 15'h4001; cpu_wr_data_i = 8'h02;
      step(1'b0);
      cpu_wr_valid_i = 1'b0;
      cpu_rd_req_i = 1'b1; cpu_rd_addr_i = 15'h4000;
      step(1'b0);
      cpu_rd_req_i = 1'b0;
      check_eq("pre_rst_fill_busy", {31'd0, fill_busy_o}, 1);
      check_eq("pre_rst_rd_busy", {31'd0, cpu_rd_busy_o}, 1);
      reset = 1'b1;
      step(1'b0);
      check_eq("mid_rst_fill_busy", {31'd0, fill_busy_o}, 0);
      check_eq("mid_rst_wr_ready", {31'd0, cpu_wr_ready_o}, 1);
      check_eq("mid_rst_rd_busy", {31'd0, cpu_rd_busy_o}, 0);
      check_eq("mid_rst_slot", {29'd0, slot_o}, 0);
      reset = 1'b0;
      wlog.delete();
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1);
         if (cpu_rd_valid_o) pulses++;
      end
      check_eq("post_rst_no_write", wlog.size(), 0);
      check_eq("post_rst_no_read", pulses, 0);
      check_eq("post_rst_fill_idle", {31'd0, fill_busy_o}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
